// File: rtl/core_pkg.sv
// Shared types and default widths for the core's hazard/scoreboard control.
package core_pkg;

   localparam int unsigned REG_AW_DEFAULT = 5;
   localparam int unsigned MC_LAT_DEFAULT = 4;
   localparam int unsigned CNT_W_DEFAULT  = 4;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      SB_IDLE = 1'b0,
      SB_BUSY = 1'b1
   } sb_state_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for the hazard unit; HAZARD_PERF_EN adds the event counters.
interface hazard_scoreboard_if #(
   parameter int unsigned REG_AW = core_pkg::REG_AW_DEFAULT
);
   logic [REG_AW-1:0] r1AddrD;
   logic [REG_AW-1:0] r2AddrD;
   logic [REG_AW-1:0] rdD;
   logic              regWriteD;
   logic              mcOpD;
   logic [REG_AW-1:0] r1AddrE;
   logic [REG_AW-1:0] r2AddrE;
   logic [REG_AW-1:0] rdE;
   logic              regSrcE0;
   logic              mcOpE;
   logic [REG_AW-1:0] rdM;
   logic [REG_AW-1:0] rdW;
   logic              regWriteM;
   logic              regWriteW;
   logic              wrongBranchE;

   core_pkg::fwd_sel_t fwdAE;
   core_pkg::fwd_sel_t fwdBE;
   logic              stallF;
   logic              stallD;
   logic              flushD;
   logic              flushE;
   logic              mcBusy;
   logic              mcWbValid;
   logic [REG_AW-1:0] mcWbRd;
`ifdef HAZARD_PERF_EN
   logic [31:0]       stallCnt;
   logic [31:0]       flushCnt;
   logic [31:0]       mcStallCnt;
`endif

   modport master (
      output r1AddrD, r2AddrD, rdD, regWriteD, mcOpD,
      output r1AddrE, r2AddrE, rdE, regSrcE0, mcOpE,
      output rdM, rdW, regWriteM, regWriteW, wrongBranchE,
      input  fwdAE, fwdBE, stallF, stallD, flushD, flushE,
      input  mcBusy, mcWbValid, mcWbRd
`ifdef HAZARD_PERF_EN
      , input stallCnt, flushCnt, mcStallCnt
`endif
   );

   modport slave (
      input  r1AddrD, r2AddrD, rdD, regWriteD, mcOpD,
      input  r1AddrE, r2AddrE, rdE, regSrcE0, mcOpE,
      input  rdM, rdW, regWriteM, regWriteW, wrongBranchE,
      output fwdAE, fwdBE, stallF, stallD, flushD, flushE,
      output mcBusy, mcWbValid, mcWbRd
`ifdef HAZARD_PERF_EN
      , output stallCnt, flushCnt, mcStallCnt
`endif
   );

endinterface

// File: rtl/mc_scoreboard.sv
// Occupancy tracker for the single fixed-latency mul/div unit: issue, countdown,
// writeback pulse, and the RAW/WAW/structural hazard terms against the in-flight op.
module mc_scoreboard
   import core_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEFAULT,
   parameter int unsigned MC_LAT = MC_LAT_DEFAULT,
   parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              op_d,
   input  logic [REG_AW-1:0] src1_d,
   input  logic [REG_AW-1:0] src2_d,
   input  logic [REG_AW-1:0] dst_d,
   input  logic              dst_we_d,
   output logic              busy,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_rd,
   output logic              raw,
   output logic              waw,
   output logic              mc_struct
);

   sb_state_t         state_q, state_d;
   logic [REG_AW-1:0] pend_q, pend_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SB_IDLE;
         pend_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
      end
   end

   // An op with rd==0 still occupies the unit; pend stays 0 so it never raises RAW/WAW.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      case (state_q)
         SB_IDLE: begin
            if (op_e) begin
               state_d = SB_BUSY;
               pend_d  = rd_e;
               cnt_d   = CNT_W'(MC_LAT - 1);
            end
         end
         SB_BUSY: begin
            if (cnt_q == '0) begin
               state_d = SB_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = SB_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == SB_BUSY);
      wb_valid  = busy && (cnt_q == '0);
      wb_rd     = pend_q;
      raw       = busy && (pend_q != '0) && ((src1_d == pend_q) || (src2_d == pend_q));
      waw       = busy && (pend_q != '0) && dst_we_d && (dst_d == pend_q);
      mc_struct = op_d && (busy || op_e);
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: M/W forwarding, load-use and long-op stalls,
// branch flushes. Optional event counters under HAZARD_PERF_EN.
module hazard_scoreboard
   import core_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEFAULT,
   parameter int unsigned MC_LAT = MC_LAT_DEFAULT,
   parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave hz
);

   logic lw_stall;
   logic mc_raw;
   logic mc_raw_issue;
   logic mc_waw;
   logic mc_struct;
   logic stall;

   function automatic fwd_sel_t fwd_sel(input logic [REG_AW-1:0] src,
                                        input logic [REG_AW-1:0] rd_m,
                                        input logic              we_m,
                                        input logic [REG_AW-1:0] rd_w,
                                        input logic              we_w);
      if (we_m && (rd_m != '0) && (src == rd_m))      return FWD_M;
      else if (we_w && (rd_w != '0) && (src == rd_w)) return FWD_W;
      else                                            return FWD_RF;
   endfunction

   mc_scoreboard #(
      .REG_AW (REG_AW),
      .MC_LAT (MC_LAT),
      .CNT_W  (CNT_W)
   ) u_mc_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .op_e      (hz.mcOpE),
      .rd_e      (hz.rdE),
      .op_d      (hz.mcOpD),
      .src1_d    (hz.r1AddrD),
      .src2_d    (hz.r2AddrD),
      .dst_d     (hz.rdD),
      .dst_we_d  (hz.regWriteD),
      .busy      (hz.mcBusy),
      .wb_valid  (hz.mcWbValid),
      .wb_rd     (hz.mcWbRd),
      .raw       (mc_raw),
      .waw       (mc_waw),
      .mc_struct (mc_struct)
   );

   // A mispredict squashes D anyway, so it overrides the hold on F/D.
   always_comb begin
      hz.fwdAE = fwd_sel(hz.r1AddrE, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
      hz.fwdBE = fwd_sel(hz.r2AddrE, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);

      lw_stall     = hz.regSrcE0 && (hz.rdE != '0) &&
                     ((hz.r1AddrD == hz.rdE) || (hz.r2AddrD == hz.rdE));
      mc_raw_issue = hz.mcOpE && (hz.rdE != '0) &&
                     ((hz.r1AddrD == hz.rdE) || (hz.r2AddrD == hz.rdE));
      stall        = lw_stall || mc_raw || mc_raw_issue || mc_waw || mc_struct;

      hz.stallF = stall && !hz.wrongBranchE;
      hz.stallD = stall && !hz.wrongBranchE;
      hz.flushD = hz.wrongBranchE;
      hz.flushE = stall || hz.wrongBranchE;
   end

`ifdef HAZARD_PERF_EN
   logic mc_any;
   assign mc_any = mc_raw || mc_raw_issue || mc_waw || mc_struct;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hz.stallCnt   <= '0;
         hz.flushCnt   <= '0;
         hz.mcStallCnt <= '0;
      end else begin
         if (hz.stallD && (hz.stallCnt != '1))   hz.stallCnt   <= hz.stallCnt + 32'd1;
         if (hz.flushE && (hz.flushCnt != '1))   hz.flushCnt   <= hz.flushCnt + 32'd1;
         if (mc_any && (hz.mcStallCnt != '1))    hz.mcStallCnt <= hz.mcStallCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MC_LAT=4): forwarding, load-use, long-op scoreboard.
module tb_hazard_scoreboard;
   import core_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.REG_AW(5)) hz ();

   hazard_scoreboard #(.REG_AW(5), .MC_LAT(4), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; inputs are driven 1ns after the edge.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      hz.r1AddrD = '0; hz.r2AddrD = '0; hz.rdD = '0; hz.regWriteD = 0; hz.mcOpD = 0;
      hz.r1AddrE = '0; hz.r2AddrE = '0; hz.rdE = '0; hz.regSrcE0 = 0; hz.mcOpE = 0;
      hz.rdM = '0; hz.rdW = '0; hz.regWriteM = 0; hz.regWriteW = 0; hz.wrongBranchE = 0;
   endtask

   task automatic chk_ctl(input string tag, input logic st, input logic fd, input logic fe);
      chk({tag, "_stallF"}, hz.stallF, st);
      chk({tag, "_stallD"}, hz.stallD, st);
      chk({tag, "_flushD"}, hz.flushD, fd);
      chk({tag, "_flushE"}, hz.flushE, fe);
   endtask

   initial begin
      rst = 1'b1;
      clr();
      next();
      next();
      rst = 1'b0;
      #2;
      chk("rst_busy", hz.mcBusy, 0);
      chk("rst_wbv", hz.mcWbValid, 0);
      chk_ctl("rst", 0, 0, 0);
      chk("rst_fwdA", hz.fwdAE, 2'b00);

      // Forwarding priority
      next();
      hz.rdM = 5; hz.rdW = 5; hz.regWriteM = 1; hz.regWriteW = 1; hz.r1AddrE = 5;
      #2;
      chk("fwd_m_pri", hz.fwdAE, 2'b10);
      chk("fwd_b_none", hz.fwdBE, 2'b00);
      hz.regWriteM = 0;
      #2;
      chk("fwd_w", hz.fwdAE, 2'b01);
      hz.r2AddrE = 5;
      #1;
      chk("fwdB_w", hz.fwdBE, 2'b01);
      hz.regWriteM = 1; hz.regWriteW = 0; hz.rdM = 6;
      #1;
      chk("fwdB_m_only_miss", hz.fwdBE, 2'b00);
      chk("fwdA_m_only_miss", hz.fwdAE, 2'b00);
      hz.rdM = 0; hz.r1AddrE = 0;
      #1;
      chk("fwd_x0", hz.fwdAE, 2'b00);

      // Load-use
      next();
      clr();
      hz.regSrcE0 = 1; hz.rdE = 7; hz.r2AddrD = 7;
      #2;
      chk_ctl("lw", 1, 0, 1);
      chk("lw_busy", hz.mcBusy, 0);
      next();
      clr();
      #2;
      chk_ctl("lw_after", 0, 0, 0);
      hz.regSrcE0 = 1; hz.rdE = 0; hz.r2AddrD = 0;
      #1;
      chk_ctl("lw_x0", 0, 0, 0);

      // Long op rd=9, dependent reader in D
      next();
      clr();
      hz.mcOpE = 1; hz.rdE = 9; hz.r1AddrD = 9;
      #2;
      chk("mc0_busy", hz.mcBusy, 0);
      chk_ctl("mc0", 1, 0, 1);
      for (int c = 1; c <= 5; c++) begin
         next();
         clr();
         hz.r1AddrD = 9;
         #2;
         chk($sformatf("mc%0d_busy", c), hz.mcBusy, (c <= 4) ? 1 : 0);
         chk($sformatf("mc%0d_wbv", c), hz.mcWbValid, (c == 4) ? 1 : 0);
         chk($sformatf("mc%0d_stall", c), hz.stallD, (c <= 4) ? 1 : 0);
         if (c == 4) chk("mc4_wbrd", hz.mcWbRd, 9);
      end

      // Structural: second long op in D
      next();
      clr();
      hz.mcOpE = 1; hz.rdE = 12; hz.mcOpD = 1;
      #2;
      chk("st0_stall", hz.stallD, 1);
      for (int c = 1; c <= 5; c++) begin
         next();
         clr();
         hz.mcOpD = 1;
         #2;
         chk($sformatf("st%0d_stall", c), hz.stallD, (c <= 4) ? 1 : 0);
      end

      // WAW on pending destination
      next();
      clr();
      hz.mcOpE = 1; hz.rdE = 3;
      #2;
      chk("waw0_stall", hz.stallD, 0);
      for (int c = 1; c <= 5; c++) begin
         next();
         clr();
         hz.regWriteD = 1; hz.rdD = 3;
         #2;
         chk($sformatf("waw%0d_stall", c), hz.stallD, (c <= 4) ? 1 : 0);
         if (c == 2) begin
            hz.rdD = 4;
            #1;
            chk("waw2_other_rd", hz.stallD, 0);
         end
      end

      // Mispredict during long op
      next();
      clr();
      hz.mcOpE = 1; hz.rdE = 9; hz.r1AddrD = 9;
      for (int c = 1; c <= 5; c++) begin
         next();
         clr();
         hz.r1AddrD = 9;
         hz.wrongBranchE = (c == 2);
         #2;
         if (c == 2) chk_ctl("br2", 0, 1, 1);
         if (c == 3) chk_ctl("br3", 1, 0, 1);
         chk($sformatf("br%0d_wbv", c), hz.mcWbValid, (c == 4) ? 1 : 0);
         if (c == 4) chk("br4_wbrd", hz.mcWbRd, 9);
      end

      // Reset mid-op
      next();
      clr();
      hz.mcOpE = 1; hz.rdE = 10;
      next();
      clr();
      hz.r1AddrD = 10;
      next();
      rst = 1'b1;
      #2;
      chk("rstm2_busy", hz.mcBusy, 1);
      next();
      rst = 1'b0;
      #2;
      chk("rstm3_busy", hz.mcBusy, 0);
      chk_ctl("rstm3", 0, 0, 0);
      for (int c = 4; c <= 6; c++) begin
         next();
         #2;
         chk($sformatf("rstm%0d_wbv", c), hz.mcWbValid, 0);
         chk($sformatf("rstm%0d_busy", c), hz.mcBusy, 0);
      end

      // Long op to x0 occupies the unit but creates no RAW
      next();
      clr();
      hz.mcOpE = 1; hz.rdE = 0;
      #2;
      chk("z0_stall", hz.stallD, 0);
      for (int c = 1; c <= 5; c++) begin
         next();
         clr();
         hz.mcOpD = (c == 3);
         #2;
         chk($sformatf("z%0d_busy", c), hz.mcBusy, (c <= 4) ? 1 : 0);
         chk($sformatf("z%0d_stall", c), hz.stallD, (c == 3) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the 5-stage core. Handles M/W forwarding, load-use stalls and branch flushes.
- Adds a scoreboard for one long-latency (mul/div) unit of fixed latency, which writes back through a dedicated register-file port.
- Stalls decode on RAW/WAW against the in-flight long op and on structural conflict for the unit.
- Purely a control block between the D/E pipeline registers and the regfile; produces no datapath values.

Parameters:
- REG_AW, 5, register address width.
- MC_LAT, 4, cycles from long-op issue (in E) to its writeback pulse; legal range 2..15.
- CNT_W, 4, width of the latency down-counter; must satisfy 2^CNT_W > MC_LAT.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- r1AddrD, r2AddrD  in  REG_AW  D-stage source addresses.
- rdD  in  REG_AW  D-stage destination.
- regWriteD  in  1  D instruction writes rdD.
- mcOpD  in  1  D instruction is a long op.
- r1AddrE, r2AddrE, rdE  in  REG_AW  E-stage addresses.
- regSrcE0  in  1  E instruction is a load.
- mcOpE  in  1  E instruction is a long op (issues this cycle).
- rdM, rdW  in  REG_AW  M/W destinations.
- regWriteM, regWriteW  in  1  M/W write enables.
- wrongBranchE  in  1  branch mispredicted in E.
- fwdAE, fwdBE  out  2  00 regfile, 01 W, 10 M.
- stallF, stallD, flushD, flushE  out  1  pipeline controls.
- mcBusy  out  1  long unit occupied.
- mcWbValid  out  1  long-op writeback this cycle.
- mcWbRd  out  REG_AW  destination of that writeback.

Behaviour:
Forwarding (combinational):
- Per source: M match (addr==rdM, rdM!=0, regWriteM) gives 10. Else W match (regWriteW) gives 01. Else 00.
- Both sources use their own M and W enables.

Scoreboard state: busy flag, pendRd[REG_AW], cnt[CNT_W].
- Issue: when mcOpE=1 and busy=0 and rdE!=0, the next cycle has busy=1, pendRd=rdE, cnt=MC_LAT-1.
- mcOpE with rdE==0 occupies the unit without a pending register.
- While busy, cnt decrements by 1 each cycle.
- mcWbValid=1 and mcWbRd=pendRd in the cycle where busy=1 and cnt==0. This is exactly MC_LAT cycles after the issue cycle.
- busy clears at the end of that cycle.
- mcBusy = busy.

Stall sources:
- lwStall: regSrcE0 and (r1AddrD==rdE or r2AddrD==rdE) and rdE!=0.
- mcRaw: r1AddrD or r2AddrD equals pendRd, with busy and pendRd!=0. Held through the writeback cycle and released the cycle after.
- mcRawIssue: mcOpE and a source equals rdE, rdE!=0.
- mcWaw: regWriteD and rdD==pendRd, with busy and pendRd!=0.
- mcStruct: mcOpD and (busy or mcOpE).
- stall = OR of all of the above.

Outputs:
- stallF = stallD = stall and not wrongBranchE.
- flushD = wrongBranchE.
- flushE = stall or wrongBranchE.
- A wrongBranchE does not cancel an already-issued long op; it completes and writes back.

Reset:
- Synchronous: busy=0, cnt=0, pendRd=0. mcWbValid=0 from the cycle after the reset edge.
- A long op in flight at reset is dropped; no writeback pulse.
- All combinational outputs follow their inputs.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs stallCnt[31:0], flushCnt[31:0] and mcStallCnt[31:0].
  - They increment on cycles with stallD=1, flushE=1 and (mcRaw|mcRawIssue|mcWaw|mcStruct)=1 respectively.
  - Saturating, cleared by rst.
- When undefined, those ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `core_pkg`:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - REG_AW default and MC_LAT default.
- One sub-module, `mc_scoreboard`, holding busy/pendRd/cnt, issue, writeback pulse and the mcRaw/mcWaw/mcStruct terms.
- Forwarding, load-use and flush logic stay in the top.

Test Plan:
- Forwarding priority: rdM=rdW=5, both writes on, r1AddrE=5 -> fwdAE=10. Drop regWriteM -> 01. Set r2AddrE=5 with only regWriteW -> fwdBE=01, never 01 from regWriteM alone.
- Load-use: regSrcE0=1, rdE=7, r2AddrD=7 -> stallF=stallD=flushE=1 for one cycle. Same with rdE=0 -> all 0.
- Long op, MC_LAT=4:
  - mcOpE with rdE=9 at cycle 0 -> mcBusy=1 on cycles 1-4, mcWbValid=1 with mcWbRd=9 on cycle 4.
  - D reading x9 stalls on cycles 0-4 and releases on cycle 5.
- Structural/WAW: mcOpD while busy -> stall until the cycle after writeback. regWriteD with rdD=pendRd -> stall likewise.
- Branch during long op: wrongBranchE on cycle 2 with stall active -> stallD=0, flushD=flushE=1, writeback still on cycle 4.
- Reset mid-op: rst at cycle 2 -> mcBusy=0 at cycle 3, no mcWbValid afterwards, stalls cleared.
